// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module   : vga_pkg
// Purpose  : Shared constants and helpers for the VGA test-pattern path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

    localparam int H_VALID  = 640;
    localparam int V_VALID  = 480;

    localparam int MODE_NUM = 4;

    typedef logic [MODE_NUM-1:0] mode_t;

    localparam mode_t MODE_RED    = 4'b0001;
    localparam mode_t MODE_ORANGE = 4'b0010;
    localparam mode_t MODE_YELLOW = 4'b0100;
    localparam mode_t MODE_CIRCLE = 4'b1000;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_AUTO   = 1'b1;

    function automatic mode_t mode_rotl(input mode_t m);
        return {m[MODE_NUM-2:0], m[MODE_NUM-1]};
    endfunction

    function automatic mode_t mode_rotr(input mode_t m);
        return {m[0], m[MODE_NUM-1:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module   : key_debounce
// Purpose  : Single active-low key: 2-FF synchroniser, debounce, press pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
    import vga_pkg::*;
#(
    parameter int DB_CYCLES = 500_000
) (
    input  logic Clk_int,
    input  logic Sys_Rst_n,
    input  logic key_n_i,
    output logic evt_o
);

    localparam int           CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          evt_q,   evt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        evt_d   = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                evt_d   = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle is released (high) so reset never manufactures a press.
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_sched.sv
//------------------------------------------------------------------------------
// Module   : vga_pattern_sched
// Purpose  : Key-driven / auto pattern mode scheduler, frame-aligned updates.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_pattern_sched
    import vga_pkg::*;
#(
    parameter int DB_CYCLES   = 500_000,
    parameter int AUTO_FRAMES = 120
) (
    input  logic                Clk_int,
    input  logic                Sys_Rst_n,
    input  logic [2:0]          key_in,
    input  logic                frame_start,
    output logic [MODE_NUM-1:0] mode_sel,
    output logic                auto_en,
    output logic [2:0]          key_evt
);

    localparam logic [9:0] FRM_LAST = 10'(AUTO_FRAMES - 1);

    mode_t      mode_q,      mode_d;
    logic [0:0] state_q,     state_d;
    logic       pend_next_q, pend_next_d;
    logic       pend_prev_q, pend_prev_d;
    logic [9:0] frm_cnt_q,   frm_cnt_d;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .Clk_int   (Clk_int),
            .Sys_Rst_n (Sys_Rst_n),
            .key_n_i   (key_in[i]),
            .evt_o     (key_evt[i])
        );
    end

    // Frame handling uses only flags latched before this cycle; events seen
    // on the frame_start cycle are deferred to the following frame.
    always_comb begin
        mode_d      = mode_q;
        state_d     = state_q;
        pend_next_d = pend_next_q;
        pend_prev_d = pend_prev_q;
        frm_cnt_d   = frm_cnt_q;

        if (frame_start) begin
            if (pend_next_q) begin
                mode_d    = mode_rotl(mode_q);
                frm_cnt_d = '0;
            end else if (pend_prev_q) begin
                mode_d    = mode_rotr(mode_q);
                frm_cnt_d = '0;
            end else if (state_q == ST_AUTO) begin
                if (frm_cnt_q == FRM_LAST) begin
                    mode_d    = mode_rotl(mode_q);
                    frm_cnt_d = '0;
                end else begin
                    frm_cnt_d = frm_cnt_q + 10'd1;
                end
            end
            pend_next_d = 1'b0;
            pend_prev_d = 1'b0;
        end

        if (key_evt[0]) pend_next_d = 1'b1;
        if (key_evt[1]) pend_prev_d = 1'b1;
        if (pend_next_d && pend_prev_d) begin
            pend_next_d = 1'b0;
            pend_prev_d = 1'b0;
        end

        // Leaving AUTO also zeroes the counter, so MANUAL always holds 0.
        if (key_evt[2]) begin
            state_d   = ~state_q;
            frm_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            mode_q      <= MODE_RED;
            state_q     <= ST_MANUAL;
            pend_next_q <= 1'b0;
            pend_prev_q <= 1'b0;
            frm_cnt_q   <= '0;
        end else begin
            mode_q      <= mode_d;
            state_q     <= state_d;
            pend_next_q <= pend_next_d;
            pend_prev_q <= pend_prev_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    assign mode_sel = mode_q;
    assign auto_en  = (state_q == ST_AUTO);

endmodule

`default_nettype wire
